// File: rtl/spram_gen2_if.sv
// Bus bundle for the spram_gen2 single-port memory model.
// The master drives address, data and the active-low strobes; the slave returns Q and status.
interface spram_gen2_if #(
   parameter int DW = 32,
   parameter int AW = 7
);
   logic [AW-1:0]   a;
   logic [DW-1:0]   d;
   logic            cen;
   logic            wen;
   logic [DW/8-1:0] bwen;
   logic            oen;
   logic [DW-1:0]   q;
   logic            init_busy;
   logic            addr_err;

   modport master (
      output a, d, cen, wen, bwen, oen,
      input  q, init_busy, addr_err
   );

   modport slave (
      input  a, d, cen, wen, bwen, oen,
      output q, init_busy, addr_err
   );
endinterface

// File: rtl/spram_gen2.sv
// Parametrised single-port synchronous SRAM model with byte masks, 1/2-cycle read
// latency, selectable read-during-write data, range checking and a post-reset zero-fill.
//
//  state   | meaning
//  S_CLEAR | zero-fill engine writing one word per cycle; user accesses ignored
//  S_READY | normal operation, user accesses decoded
module spram_gen2 #(
   parameter int DW       = 32,
   parameter int DEPTH    = 128,
   parameter int AW       = 7,
   parameter int RD_LAT   = 1,
   parameter int WR_MODE  = 0,
   parameter int INIT_CLR = 1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   spram_gen2_if.slave bus
);

   localparam int            NB      = DW / 8;
   localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);
   localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

   typedef enum logic {S_CLEAR, S_READY} state_e;

   state_e          state_q;
   logic [AW-1:0]   clr_cnt_q;
   logic            busy_q;

   logic [DW-1:0]   mem_q [DEPTH];

   logic            acc;
   logic            wr;
   logic            in_rng;
   logic [DW-1:0]   old_word;
   logic [DW-1:0]   merged;
   logic [DW-1:0]   rd_d;

   logic [DW-1:0]   rd_q;
   logic            err1_q;
   logic            acc1_q;
   logic [DW-1:0]   q2_q;
   logic            err2_q;
   logic [DW-1:0]   q_reg;
   logic            err_reg;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= (INIT_CLR != 0) ? S_CLEAR : S_READY;
         clr_cnt_q <= '0;
         busy_q    <= (INIT_CLR != 0);
      end else begin
         case (state_q)
            S_CLEAR: begin
               if (clr_cnt_q == LAST) begin
                  state_q <= S_READY;
                  busy_q  <= 1'b0;
               end else begin
                  clr_cnt_q <= clr_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_READY;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign acc      = (state_q == S_READY) && !bus.cen;
   assign wr       = acc && !bus.wen;
   assign in_rng   = ({1'b0, bus.a} < DEPTH_W);
   assign old_word = mem_q[bus.a];

   always_comb begin
      merged = old_word;
      for (int i = 0; i < NB; i++) begin
         if (!bus.bwen[i]) merged[8*i +: 8] = bus.d[8*i +: 8];
      end
   end

   always_comb begin
      rd_d = '0;
      if (in_rng) begin
         if (wr) begin
            case (WR_MODE)
               1:       rd_d = merged;
               2:       rd_d = old_word;
               default: rd_d = {DW{1'bx}};
            endcase
         end else begin
            rd_d = old_word;
         end
      end
   end

   // Array has no reset; the clear engine owns the write port while busy.
   always_ff @(posedge clk_i) begin
      if (state_q == S_CLEAR) begin
         mem_q[clr_cnt_q] <= '0;
      end else if (wr && in_rng) begin
         mem_q[bus.a] <= merged;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_q   <= '0;
         err1_q <= 1'b0;
         acc1_q <= 1'b0;
         q2_q   <= '0;
         err2_q <= 1'b0;
      end else begin
         acc1_q <= acc;
         err1_q <= acc && !in_rng;
         if (acc) rd_q <= rd_d;
         if (acc1_q) q2_q <= rd_q;
         err2_q <= err1_q;
      end
   end

   assign q_reg   = (RD_LAT == 2) ? q2_q   : rd_q;
   assign err_reg = (RD_LAT == 2) ? err2_q : err1_q;

   assign bus.q         = bus.oen ? '0 : q_reg;
   assign bus.init_busy = busy_q;
   assign bus.addr_err  = err_reg;

endmodule

// File: tb/tb_spram_gen2.sv
// Three spram_gen2 variants driven by shared stimulus and checked every cycle
// against an access-history model; directed literals pin the model's key cases.
module tb_spram_gen2;

   localparam int NI   = 3;
   localparam int HMAX = 8192;
   localparam int P_DEPTH [NI] = '{128, 80, 128};
   localparam int P_LAT   [NI] = '{1, 2, 1};
   localparam int P_MODE  [NI] = '{0, 2, 1};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [6:0]  a_s = '0;
   logic [31:0] d_s = '0;
   logic        cen_s = 1'b1;
   logic        wen_s = 1'b1;
   logic [3:0]  bwen_s = 4'hF;
   logic        oen_s = 1'b0;

   logic [31:0] q_o    [NI];
   logic        busy_o [NI];
   logic        err_o  [NI];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   spram_gen2_if #(.DW(32), .AW(7)) if0 ();
   spram_gen2_if #(.DW(32), .AW(7)) if1 ();
   spram_gen2_if #(.DW(32), .AW(7)) if2 ();

   assign if0.a = a_s;  assign if0.d = d_s;  assign if0.cen = cen_s;
   assign if0.wen = wen_s; assign if0.bwen = bwen_s; assign if0.oen = oen_s;
   assign if1.a = a_s;  assign if1.d = d_s;  assign if1.cen = cen_s;
   assign if1.wen = wen_s; assign if1.bwen = bwen_s; assign if1.oen = oen_s;
   assign if2.a = a_s;  assign if2.d = d_s;  assign if2.cen = cen_s;
   assign if2.wen = wen_s; assign if2.bwen = bwen_s; assign if2.oen = oen_s;

   assign q_o[0] = if0.q; assign busy_o[0] = if0.init_busy; assign err_o[0] = if0.addr_err;
   assign q_o[1] = if1.q; assign busy_o[1] = if1.init_busy; assign err_o[1] = if1.addr_err;
   assign q_o[2] = if2.q; assign busy_o[2] = if2.init_busy; assign err_o[2] = if2.addr_err;

   spram_gen2 #(.DW(32), .DEPTH(128), .AW(7), .RD_LAT(1), .WR_MODE(0), .INIT_CLR(1))
      u0 (.clk_i(clk), .rst_i(rst), .bus(if0));
   spram_gen2 #(.DW(32), .DEPTH(80), .AW(7), .RD_LAT(2), .WR_MODE(2), .INIT_CLR(1))
      u1 (.clk_i(clk), .rst_i(rst), .bus(if1));
   spram_gen2 #(.DW(32), .DEPTH(128), .AW(7), .RD_LAT(1), .WR_MODE(1), .INIT_CLR(1))
      u2 (.clk_i(clk), .rst_i(rst), .bus(if2));

   // Model: per-edge access record (value Q must eventually show, error flag,
   // don't-care for legacy X writes) plus a word array per instance.
   logic [31:0] mm    [NI][128];
   bit          r_acc [NI][HMAX];
   bit          r_err [NI][HMAX];
   bit          r_dc  [NI][HMAX];
   logic [31:0] r_val [NI][HMAX];
   int          ecnt     = 0;
   int          since    = 0;
   int          rst_edge = 0;

   always @(posedge clk) begin
      logic [31:0] nw;
      ecnt++;
      for (int i = 0; i < NI; i++) begin
         r_acc[i][ecnt] = 1'b0;
         r_err[i][ecnt] = 1'b0;
         r_dc[i][ecnt]  = 1'b0;
         r_val[i][ecnt] = '0;
      end
      if (rst) begin
         since    = 0;
         rst_edge = ecnt;
         for (int i = 0; i < NI; i++)
            for (int w = 0; w < 128; w++) mm[i][w] = '0;
      end else begin
         for (int i = 0; i < NI; i++) begin
            if (since >= P_DEPTH[i] && !cen_s) begin
               r_acc[i][ecnt] = 1'b1;
               if (int'(a_s) >= P_DEPTH[i]) begin
                  r_err[i][ecnt] = 1'b1;
               end else if (!wen_s) begin
                  nw = mm[i][a_s];
                  for (int b = 0; b < 4; b++)
                     if (!bwen_s[b]) nw[8*b +: 8] = d_s[8*b +: 8];
                  if (P_MODE[i] == 1) r_val[i][ecnt] = nw;
                  else if (P_MODE[i] == 2) r_val[i][ecnt] = mm[i][a_s];
                  else r_dc[i][ecnt] = 1'b1;
                  mm[i][a_s] = nw;
               end else begin
                  r_val[i][ecnt] = mm[i][a_s];
               end
            end
         end
         since++;
      end
   end

   // Compare process: every cycle, every instance, every output.
   always @(posedge clk) begin
      #1;
      for (int i = 0; i < NI; i++) begin
         int          idx;
         logic [31:0] ev;
         bit          edc;
         bit          eb;
         bit          ee;
         idx = ecnt - (P_LAT[i] - 1);
         ev  = '0;
         edc = 1'b0;
         for (int m = idx; m > rst_edge; m--) begin
            if (r_acc[i][m]) begin
               ev  = r_val[i][m];
               edc = r_dc[i][m];
               break;
            end
         end
         eb = rst ? 1'b1 : (since < P_DEPTH[i]);
         ee = !rst && idx > rst_edge && r_acc[i][idx] && r_err[i][idx];
         checks++;
         if (busy_o[i] !== eb) begin
            errors++;
            $display("FAIL busy u%0d edge %0d: got %b expected %b", i, ecnt, busy_o[i], eb);
         end
         checks++;
         if (err_o[i] !== ee) begin
            errors++;
            $display("FAIL addr_err u%0d edge %0d: got %b expected %b", i, ecnt, err_o[i], ee);
         end
         if (oen_s || !edc) begin
            checks++;
            if (q_o[i] !== (oen_s ? 32'h0 : ev)) begin
               errors++;
               $display("FAIL q u%0d edge %0d: got %h expected %h", i, ecnt, q_o[i],
                        oen_s ? 32'h0 : ev);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One access: drive at the falling edge, return 1 time unit after the rising edge.
   task automatic acc(input logic c, input logic w, input logic [6:0] ad,
                      input logic [31:0] dd, input logic [3:0] bw, input logic oe);
      @(negedge clk);
      cen_s = c; wen_s = w; a_s = ad; d_s = dd; bwen_s = bw; oen_s = oe;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_rand();
      cen_s  = ($urandom_range(3) == 0);
      wen_s  = $urandom_range(1) == 1;
      a_s    = ($urandom_range(1) == 1) ? 7'($urandom_range(7)) : 7'($urandom_range(127));
      d_s    = $urandom;
      bwen_s = 4'($urandom_range(15));
      oen_s  = ($urandom_range(7) == 0);
   endtask

   // Called right at a falling edge just after reset release.
   task automatic count_busy(output int n);
      n = 0;
      for (int k = 0; k < 300; k++) begin
         drive_rand();
         @(posedge clk);
         #1;
         n++;
         if (!busy_o[0]) break;
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      count_busy(n);
      chk("T1 busy cycles", 32'(n), 32'd128);

      acc(1'b0, 1'b1, 7'd0,   '0, 4'hF, 1'b0); chk("T1 read 0",   q_o[0], 32'h0);
      acc(1'b0, 1'b1, 7'd64,  '0, 4'hF, 1'b0); chk("T1 read 64",  q_o[0], 32'h0);
      acc(1'b0, 1'b1, 7'd127, '0, 4'hF, 1'b0); chk("T1 read 127", q_o[0], 32'h0);

      acc(1'b0, 1'b0, 7'd5, 32'hAABBCCDD, 4'h0, 1'b0);
      acc(1'b0, 1'b0, 7'd5, 32'h11223344, 4'b1010, 1'b0);
      chk("T2 write-through merge", q_o[2], 32'hAA22CC44);
      acc(1'b0, 1'b1, 7'd5, '0, 4'hF, 1'b0);
      chk("T2 read u0", q_o[0], 32'hAA22CC44);
      chk("T2 read u2", q_o[2], 32'hAA22CC44);

      acc(1'b0, 1'b0, 7'd9, 32'h12345678, 4'h0, 1'b0);
      acc(1'b0, 1'b0, 7'd9, 32'hCAFEF00D, 4'h0, 1'b0);
      chk("T4 mode1 new data", q_o[2], 32'hCAFEF00D);
      acc(1'b1, 1'b1, 7'd0, '0, 4'hF, 1'b0);
      chk("T4 mode2 old data", q_o[1], 32'h12345678);

      acc(1'b0, 1'b0, 7'd1, 32'h11111111, 4'h0, 1'b0);
      acc(1'b0, 1'b0, 7'd2, 32'h22222222, 4'h0, 1'b0);
      acc(1'b0, 1'b0, 7'd3, 32'h33333333, 4'h0, 1'b0);
      acc(1'b0, 1'b1, 7'd1, '0, 4'hF, 1'b0);
      acc(1'b0, 1'b1, 7'd2, '0, 4'hF, 1'b0);
      chk("T3 lat2 word1", q_o[1], 32'h11111111);
      acc(1'b0, 1'b1, 7'd3, '0, 4'hF, 1'b1);
      chk("T3 oen masks", q_o[1], 32'h0);
      acc(1'b1, 1'b1, 7'd0, '0, 4'hF, 1'b0);
      chk("T3 lat2 word3", q_o[1], 32'h33333333);
      acc(1'b1, 1'b1, 7'd0, '0, 4'hF, 1'b0);
      chk("T3 q holds", q_o[1], 32'h33333333);

      acc(1'b0, 1'b0, 7'd20,  32'h5A5A5A5A, 4'h0, 1'b0);
      acc(1'b0, 1'b0, 7'd100, 32'h0000DEAD, 4'h0, 1'b0);
      acc(1'b0, 1'b1, 7'd100, '0, 4'hF, 1'b0);
      chk("T5 err on write", 32'(err_o[1]), 32'd1);
      acc(1'b0, 1'b1, 7'd20, '0, 4'hF, 1'b0);
      chk("T5 err on read", 32'(err_o[1]), 32'd1);
      chk("T5 oor read q", q_o[1], 32'h0);
      acc(1'b1, 1'b1, 7'd0, '0, 4'hF, 1'b0);
      chk("T5 addr 20 intact", q_o[1], 32'h5A5A5A5A);
      chk("T5 err pulse ends", 32'(err_o[1]), 32'd0);

      for (int k = 0; k < 2000; k++) begin
         @(negedge clk);
         drive_rand();
      end

      @(negedge clk);
      rst = 1'b1;
      cen_s = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      count_busy(n);
      chk("T6 busy after mid-clear reset", 32'(n), 32'd128);

      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         drive_rand();
      end
      @(negedge clk);
      cen_s = 1'b1;
      repeat (3) @(negedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
